// File: rtl/wasm_global_section_loader.sv
// WebAssembly global section (id 6) body parser: decodes the LEB128 count, then
// valtype / mutability / constant init expression per global, and writes each one out.
package wasm_pkg;
    typedef enum logic [1:0] {
        VT_I32 = 2'd0,
        VT_I64 = 2'd1,
        VT_F32 = 2'd2,
        VT_F64 = 2'd3
    } valtype_t;

    typedef struct packed {
        valtype_t    vtype;
        logic        mutable_flag;
        logic [63:0] value;
    } global_entry_t;
endpackage

module wasm_global_section_loader
    import wasm_pkg::*;
#(
    parameter int NUM_GLOBALS = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          init_en,
    output logic [7:0]    init_idx,
    output global_entry_t init_data,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [2:0]    err_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_COUNT, S_VTYPE, S_MUT, S_OPCODE, S_IMM_LEB,
        S_IMM_BYTES, S_END, S_EMIT, S_DONE, S_ERR
    } state_t;

    state_t        state_q;
    logic [34:0]   cnt_acc_q;
    logic [8:0]    count_q;
    logic [7:0]    idx_q;
    logic [3:0]    byte_cnt_q;
    valtype_t      vtype_q;
    logic          mut_q;
    logic [63:0]   value_q;
    logic          init_en_q;
    logic [7:0]    init_idx_q;
    global_entry_t init_data_q;
    logic          done_q;
    logic          error_q;
    logic [2:0]    err_code_q;

    logic          hs;
    logic [6:0]    shamt;
    logic [34:0]   cnt_sum;
    logic [70:0]   imm_sum;
    logic [3:0]    leb_last;
    logic [7:0]    exp_op;
    logic          err_hit;
    logic [2:0]    err_val;

    assign in_ready  = (state_q inside {S_COUNT, S_VTYPE, S_MUT, S_OPCODE,
                                        S_IMM_LEB, S_IMM_BYTES, S_END});
    assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    assign hs        = in_valid && in_ready;
    assign init_en   = init_en_q;
    assign init_idx  = init_idx_q;
    assign init_data = init_data_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

    // LEB accumulation and per-state byte validation for the byte on in_data
    always_comb begin
        shamt    = {3'b000, byte_cnt_q} * 7'd7;
        cnt_sum  = cnt_acc_q | (35'(in_data[6:0]) << shamt);
        imm_sum  = 71'(value_q) | (71'(in_data[6:0]) << shamt);
        if (!in_data[7] && in_data[6]) begin
            imm_sum = imm_sum | ({71{1'b1}} << (shamt + 7'd7));
        end
        leb_last = (vtype_q == VT_I32) ? 4'd4 : 4'd9;
        exp_op   = 8'h41 + {6'b000000, vtype_q};
        err_hit  = 1'b0;
        err_val  = 3'd0;
        case (state_q)
            S_COUNT: begin
                if (in_data[7] && byte_cnt_q == 4'd4) begin
                    err_hit = 1'b1; err_val = 3'd5;
                end else if (!in_data[7] && cnt_sum > 35'(NUM_GLOBALS)) begin
                    err_hit = 1'b1; err_val = 3'd6;
                end
            end
            S_VTYPE:  if (!(in_data inside {[8'h7C:8'h7F]})) begin err_hit = 1'b1; err_val = 3'd1; end
            S_MUT:    if (in_data > 8'h01) begin err_hit = 1'b1; err_val = 3'd2; end
            S_OPCODE: if (in_data != exp_op) begin err_hit = 1'b1; err_val = 3'd3; end
            S_IMM_LEB: if (in_data[7] && byte_cnt_q == leb_last) begin err_hit = 1'b1; err_val = 3'd5; end
            S_END:    if (in_data != 8'h0B) begin err_hit = 1'b1; err_val = 3'd4; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_acc_q   <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            byte_cnt_q  <= '0;
            vtype_q     <= VT_I32;
            mut_q       <= 1'b0;
            value_q     <= '0;
            init_en_q   <= 1'b0;
            init_idx_q  <= '0;
            init_data_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= '0;
        end else begin
            init_en_q <= 1'b0;
            if (hs && err_hit) begin
                state_q    <= S_ERR;
                error_q    <= 1'b1;
                err_code_q <= err_val;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE, S_ERR: if (start) begin
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_code_q <= '0;
                        idx_q      <= '0;
                        cnt_acc_q  <= '0;
                        byte_cnt_q <= '0;
                        state_q    <= S_COUNT;
                    end
                    S_COUNT: if (hs) begin
                        if (in_data[7]) begin
                            cnt_acc_q  <= cnt_sum;
                            byte_cnt_q <= byte_cnt_q + 4'd1;
                        end else if (cnt_sum == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            count_q <= cnt_sum[8:0];
                            state_q <= S_VTYPE;
                        end
                    end
                    S_VTYPE: if (hs) begin
                        vtype_q <= valtype_t'(~in_data[1:0]);
                        state_q <= S_MUT;
                    end
                    S_MUT: if (hs) begin
                        mut_q   <= in_data[0];
                        state_q <= S_OPCODE;
                    end
                    S_OPCODE: if (hs) begin
                        byte_cnt_q <= '0;
                        value_q    <= '0;
                        state_q    <= (vtype_q inside {VT_I32, VT_I64}) ? S_IMM_LEB : S_IMM_BYTES;
                    end
                    S_IMM_LEB: if (hs) begin
                        byte_cnt_q <= byte_cnt_q + 4'd1;
                        if (in_data[7]) begin
                            value_q <= imm_sum[63:0];
                        end else begin
                            value_q <= (vtype_q == VT_I32) ? {32'h0, imm_sum[31:0]} : imm_sum[63:0];
                            state_q <= S_END;
                        end
                    end
                    S_IMM_BYTES: if (hs) begin
                        value_q[{byte_cnt_q[2:0], 3'b000} +: 8] <= in_data;
                        byte_cnt_q <= byte_cnt_q + 4'd1;
                        if (byte_cnt_q == ((vtype_q == VT_F32) ? 4'd3 : 4'd7)) begin
                            state_q <= S_END;
                        end
                    end
                    S_END: if (hs) begin
                        init_en_q   <= 1'b1;
                        init_idx_q  <= idx_q;
                        init_data_q <= '{vtype: vtype_q, mutable_flag: mut_q, value: value_q};
                        state_q     <= S_EMIT;
                    end
                    S_EMIT: begin
                        idx_q <= idx_q + 8'd1;
                        if (({1'b0, idx_q} + 9'd1) < count_q) begin
                            state_q <= S_VTYPE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wasm_global_section_loader.sv
// Directed bench for wasm_global_section_loader: single/multi globals, backpressure,
// error codes, empty section, asynchronous reset mid-parse and start handling.
module tb_wasm_global_section_loader;
    import wasm_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          init_en;
    logic [7:0]    init_idx;
    global_entry_t init_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    err_code;

    int n_chk  = 0;
    int n_fail = 0;
    int n_emit = 0;
    int base;
    logic [7:0] seq[$];
    logic [79:0] err_vec[6];
    int          err_len[6];
    logic [2:0]  err_exp[6];

    wasm_global_section_loader #(.NUM_GLOBALS(256)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .init_en(init_en), .init_idx(init_idx), .init_data(init_data),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (init_en === 1'b1) n_emit++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic send(input logic [7:0] b, input int gap);
        bit got;
        got = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 200 && !got; i++) begin
            got = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 64'(got), 64'd1);
    endtask

    task automatic send_seq(input int maxgap);
        foreach (seq[i]) send(seq[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    endtask

    task automatic chk_emit(input string tag, input logic [7:0] idx, input valtype_t vt,
                            input logic mut, input logic [63:0] val);
        chk({tag, "_en"},   64'(init_en), 64'd1);
        chk({tag, "_idx"},  64'(init_idx), 64'(idx));
        chk({tag, "_vt"},   64'(init_data.vtype), 64'(vt));
        chk({tag, "_mut"},  64'(init_data.mutable_flag), 64'(mut));
        chk({tag, "_val"},  init_data.value, val);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        err_vec[0] = 80'h017B_0000_0000_0000_0000; err_len[0] = 2; err_exp[0] = 3'd1;
        err_vec[1] = 80'h017F_0200_0000_0000_0000; err_len[1] = 3; err_exp[1] = 3'd2;
        err_vec[2] = 80'h017F_0042_0000_0000_0000; err_len[2] = 4; err_exp[2] = 3'd3;
        err_vec[3] = 80'h017F_0041_0500_0000_0000; err_len[3] = 6; err_exp[3] = 3'd4;
        err_vec[4] = 80'h017F_0041_FFFF_FFFF_FF0F; err_len[4] = 9; err_exp[4] = 3'd5;
        err_vec[5] = 80'h8102_0000_0000_0000_0000; err_len[5] = 2; err_exp[5] = 3'd6;

        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_code",  64'(err_code), 64'd0);
        chk("rst_en",    64'(init_en), 64'd0);
        chk("rst_idx",   64'(init_idx), 64'd0);
        chk("rst_data",  init_data.value, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(in_ready), 64'd0);

        // Single i32 global, with an ignored start pulse mid-parse
        base = n_emit;
        pulse_start();
        chk("t1_busy", 64'(busy), 64'd1);
        seq = '{8'h01, 8'h7F};
        send_seq(0);
        pulse_start();
        seq = '{8'h01, 8'h41, 8'h7B, 8'h0B};
        send_seq(0);
        chk_emit("t1", 8'd0, VT_I32, 1'b1, 64'h0000_0000_FFFF_FFFB);
        @(negedge clk);
        chk("t1_en_off", 64'(init_en), 64'd0);
        chk("t1_done",   64'(done), 64'd1);
        chk("t1_ready",  64'(in_ready), 64'd0);
        chk("t1_nemit",  64'(n_emit - base), 64'd1);

        // Restart from DONE; two globals with random backpressure
        base = n_emit;
        pulse_start();
        chk("t2_done_clr", 64'(done), 64'd0);
        seq = '{8'h02, 8'h7C, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'hF0, 8'h3F, 8'h0B};
        send_seq(2);
        chk_emit("t2g0", 8'd0, VT_F64, 1'b0, 64'h3FF0_0000_0000_0000);
        seq = '{8'h7E, 8'h00, 8'h42, 8'h80, 8'h01, 8'h0B};
        send_seq(2);
        chk_emit("t2g1", 8'd1, VT_I64, 1'b0, 64'h0000_0000_0000_0080);
        @(negedge clk);
        chk("t2_done",  64'(done), 64'd1);
        chk("t2_nemit", 64'(n_emit - base), 64'd2);

        // Empty section: trailing bytes are not consumed
        base = n_emit;
        pulse_start();
        send(8'h00, 0);
        chk("t3_done",  64'(done), 64'd1);
        chk("t3_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_data = 8'h7F;
        repeat (3) @(negedge clk);
        chk("t3_ready_hold", 64'(in_ready), 64'd0);
        chk("t3_done_hold",  64'(done), 64'd1);
        in_valid = 1'b0;
        chk("t3_nemit", 64'(n_emit - base), 64'd0);

        // Error table, each run restarted by start
        for (int t = 0; t < 6; t++) begin
            base = n_emit;
            pulse_start();
            chk($sformatf("e%0d_err_clr", t), 64'(error), 64'd0);
            for (int i = 0; i < err_len[t]; i++) send(err_vec[t][79 - 8*i -: 8], 0);
            chk($sformatf("e%0d_error", t), 64'(error), 64'd1);
            chk($sformatf("e%0d_code", t),  64'(err_code), 64'(err_exp[t]));
            chk($sformatf("e%0d_busy", t),  64'(busy), 64'd0);
            @(negedge clk);
            chk($sformatf("e%0d_ready", t), 64'(in_ready), 64'd0);
            chk($sformatf("e%0d_nemit", t), 64'(n_emit - base), 64'd0);
        end

        // Asynchronous reset in the middle of an immediate
        base = n_emit;
        pulse_start();
        seq = '{8'h01, 8'h7F, 8'h01, 8'h41};
        send_seq(0);
        chk("r_busy_pre", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("r_ready", 64'(in_ready), 64'd0);
        chk("r_busy",  64'(busy), 64'd0);
        chk("r_idx",   64'(init_idx), 64'd0);
        chk("r_data",  init_data.value, 64'd0);
        chk("r_code",  64'(err_code), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("r_nemit", 64'(n_emit - base), 64'd0);

        // Fresh parse after reset: multi-byte i32 then f32
        base = n_emit;
        pulse_start();
        seq = '{8'h02, 8'h7F, 8'h00, 8'h41, 8'hE5, 8'h8E, 8'h26, 8'h0B};
        send_seq(1);
        chk_emit("f0", 8'd0, VT_I32, 1'b0, 64'h0000_0000_0009_8765);
        seq = '{8'h7D, 8'h01, 8'h43, 8'h00, 8'h00, 8'h80, 8'h3F, 8'h0B};
        send_seq(1);
        chk_emit("f1", 8'd1, VT_F32, 1'b1, 64'h0000_0000_3F80_0000);
        @(negedge clk);
        chk("f_done",  64'(done), 64'd1);
        chk("f_nemit", 64'(n_emit - base), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wasm_global_section_loader.md
Name: wasm_global_section_loader

Overview:
- Parses the body of a WebAssembly global section (id 6) from a byte stream and writes each decoded global into the globals store through its init interface.
- Sits between the module-loader byte stream and the globals storage.
- Decodes the LEB128 global count, then for each global: valtype, mutability and a constant init expression.
- Emits one init write per global, with the global index assigned in order.

Parameters:
- NUM_GLOBALS, 256, capacity of the downstream globals store; a count greater than this is an error.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse; begins parsing at the first byte of the section body (after section id/size)
- in_valid  input  1  byte available
- in_data  input  8  section byte
- in_ready  output  1  byte accepted when in_valid && in_ready
- init_en  output  1  one-cycle write strobe to the globals store
- init_idx  output  8  global index being written
- init_data  output  global_entry_t  fields vtype, mutable_flag, value[63:0]
- busy  output  1  parse in progress
- done  output  1  sticky; section parsed successfully
- error  output  1  sticky; parse aborted
- err_code  output  3  0 none, 1 bad valtype, 2 bad mutability, 3 opcode mismatch/unsupported, 4 missing end (0x0B), 5 LEB overflow, 6 too many globals

Behaviour:
- Reset (asynchronous, any state): state IDLE; in_ready, init_en, busy, done and error are 0; init_idx, init_data and err_code are 0. No init_en is produced after reset, including mid-parse.
- start is honoured only in IDLE, DONE or ERR. It clears done, error and err_code and the global counter, and enters COUNT the next cycle. start while busy is ignored.
- States: IDLE, COUNT, VTYPE, MUT, OPCODE, IMM_LEB, IMM_BYTES, END, EMIT, DONE, ERR.
- in_ready is 1 exactly in COUNT, VTYPE, MUT, OPCODE, IMM_LEB, IMM_BYTES and END. busy is 1 in every state except IDLE, DONE and ERR.
- COUNT: unsigned LEB128, at most 5 bytes.
  - A 5th byte with its continuation bit set gives error 5.
  - count > NUM_GLOBALS gives error 6.
  - count == 0 goes to DONE.
- VTYPE: 0x7F i32, 0x7E i64, 0x7D f32, 0x7C f64; stored as the wasm_pkg valtype code. Any other byte gives error 1.
- MUT: 0x00 makes mutable_flag 0, 0x01 makes it 1; any other byte gives error 2.
- OPCODE: must match the valtype: 0x41 for i32, 0x42 for i64, 0x43 for f32, 0x44 for f64. Any other byte, including 0x23 global.get, gives error 3.
- IMM_LEB (i32/i64): signed LEB128, at most 5 bytes for i32 and 10 for i64; exceeding the limit gives error 5.
  - If bit 6 of the final byte is 1, sign-extend to 32 bits (i32) or 64 bits (i64).
  - i32 result sits in value[31:0]; value[63:32] is 0.
- IMM_BYTES: little-endian raw bits, 4 bytes for f32 (value[63:32] = 0) or 8 bytes for f64. Byte counter increments only on handshake.
- END: byte must be 0x0B, otherwise error 4. On 0x0B go to EMIT.
- EMIT, one cycle: init_en = 1, init_idx = current index, init_data held stable; in_ready = 0.
  - Next state is VTYPE if index+1 < count, else DONE.
  - The index increments after EMIT.
- Latency: init_en is asserted the cycle after the 0x0B handshake.
- Stalls: in_valid low stalls the FSM indefinitely with no timeout. All state advances only on handshake, except EMIT.
- Any error enters ERR: error = 1, err_code latched, no init_en for the partially parsed global. Globals emitted earlier are not retracted.
- DONE: done = 1, in_ready = 0. Bytes after the last global are not consumed.

Test Plan:
- Single i32 global: start, bytes 01 7F 01 41 7B 0B → exactly one init_en, one cycle after the 0B handshake; init_idx=0, vtype=i32, mutable_flag=1, value=0x00000000_FFFFFFFB; then done=1.
- Two globals with backpressure: 02 7C 00 44 00 00 00 00 00 00 F0 3F 0B 7E 00 42 80 01 0B, with in_valid randomly deasserted → idx0 f64 immutable value=0x3FF0000000000000; idx1 i64 value=0x80; done=1.
- Errors, each bench independent:
  - 01 7B → error, err_code=1.
  - 01 7F 02 → err_code=2.
  - 01 7F 00 42 → err_code=3.
  - 01 7F 00 41 05 00 → err_code=4.
  - 01 7F 00 41 FF FF FF FF FF 0F → err_code=5.
  - count byte 0x81 0x02 (257) with NUM_GLOBALS=256 → err_code=6.
  - No init_en in any of these.
- Count 0: start, byte 00 → done the next cycle, no init_en, in_ready=0 afterwards.
- Reset mid-parse: assert rst after 01 7F 01 41 → all outputs 0 asynchronously, no init_en; a fresh start then parses a full section correctly from idx 0.
- start while busy is ignored; start in DONE clears done and restarts with idx 0.
